// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// master: the surrounding system (CPU fetch unit plus main memory).
// slave:  the cache itself.
interface inst_cache_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);

    // CPU fetch port
    logic              cpu_ce;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_busy;
    logic              cpu_valid;
    logic [INST_W-1:0] cpu_inst;

    // Main memory refill port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [INST_W-1:0] mem_rdata;

    // Invalidate-all request
    logic              flush;

    modport master (
        output cpu_ce, cpu_addr, flush, mem_rvalid, mem_rdata,
        input  cpu_busy, cpu_valid, cpu_inst, mem_req, mem_addr
    );

    modport slave (
        input  cpu_ce, cpu_addr, flush, mem_rvalid, mem_rdata,
        output cpu_busy, cpu_valid, cpu_inst, mem_req, mem_addr
    );

endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache.
// Hits answer one cycle after the request; misses refill a whole line from
// memory one beat at a time and answer one cycle after the last beat.
module inst_cache #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        rst,
    inst_cache_if.slave bus
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_t;

    // Cache storage: valid bits are reset, tags and data are not.
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [INST_W-1:0] data_mem [SETS*LINE_WORDS];

    state_t            state;
    logic              flush_pend;
    logic [OFF_W-1:0]  beat;
    logic [OFF_W-1:0]  beat_next;
    logic              beat_last;
    logic              fill_en;

    // Address of the request that missed, held for the whole refill
    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic [OFF_W-1:0]  lat_off;

    // Registered outputs
    logic              cpu_valid_q;
    logic              cpu_busy_q;
    logic [INST_W-1:0] cpu_inst_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;

    // Fields of the incoming fetch address
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit;

    // The byte-select bits of the fetch address are never used
    logic              unused_addr_bits;

    assign req_tag          = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_idx          = bus.cpu_addr[OFF_W+2 +: IDX_W];
    assign req_off          = bus.cpu_addr[2 +: OFF_W];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    // A flush in the same cycle forces a miss even if the line looks valid
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !bus.flush;

    assign beat_next = beat + OFF_W'(1);
    assign beat_last = (beat == OFF_W'(LINE_WORDS - 1));
    assign fill_en   = (state == REFILL) && mem_req_q && bus.mem_rvalid;

    assign bus.cpu_valid = cpu_valid_q;
    assign bus.cpu_busy  = cpu_busy_q;
    assign bus.cpu_inst  = cpu_inst_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;

    // Write each returned refill beat into the line, and the tag on the last beat
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[{lat_idx, beat}] <= bus.mem_rdata;
            if (beat_last) begin
                tag_mem[lat_idx] <= lat_tag;
            end
        end
    end

    // Control FSM: hit lookup, refill sequencing, flush tracking and all outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid       <= '0;
            flush_pend  <= 1'b0;
            beat        <= '0;
            lat_tag     <= '0;
            lat_idx     <= '0;
            lat_off     <= '0;
            cpu_valid_q <= 1'b0;
            cpu_busy_q  <= 1'b0;
            cpu_inst_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            cpu_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end
                    if (bus.cpu_ce) begin
                        if (hit) begin
                            cpu_valid_q <= 1'b1;
                            cpu_inst_q  <= data_mem[{req_idx, req_off}];
                        end else begin
                            lat_tag        <= req_tag;
                            lat_idx        <= req_idx;
                            lat_off        <= req_off;
                            valid[req_idx] <= 1'b0;
                            beat           <= '0;
                            cpu_busy_q     <= 1'b1;
                            mem_req_q      <= 1'b1;
                            mem_addr_q     <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                            state          <= REFILL;
                        end
                    end
                end

                REFILL: begin
                    if (bus.flush) begin
                        valid      <= '0;
                        flush_pend <= 1'b1;
                    end
                    if (fill_en) begin
                        if (lat_off == beat) begin
                            cpu_inst_q <= bus.mem_rdata;
                        end
                        beat       <= beat_next;
                        mem_addr_q <= {lat_tag, lat_idx, beat_next, 2'b00};
                        if (beat_last) begin
                            valid[lat_idx] <= !(flush_pend || bus.flush);
                            mem_req_q      <= 1'b0;
                            cpu_busy_q     <= 1'b0;
                            cpu_valid_q    <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (bus.flush) begin
                        valid <= '0;
                    end
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
